mult_share_arbiter: RTL and testbench

- Shares one combinational 32x32 unsigned multiplier datapath among N requesters.
- Performs round-robin arbitration and latches the winner's operands.
- Drives the multiplier for a fixed settle window of MUL_LAT cycles, then captures the 64-bit product.
- Returns the product with the requester's ID over a valid/ready response channel.
- Sits between client blocks and the Wallace-tree multiplier in the chip top level.

---
 rtl/mult_share_arbiter_if.sv | 35 +++
 rtl/mult_share_arbiter.sv | 109 ++++++++++
 tb/tb_mult_share_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// Bus bundle between N requesters, the shared multiplier and the response consumer.
// slave  : the arbiter's view (requests in, grants/multiplier operands/response out).
// master : the environment's view (requesters, multiplier and consumer).
//   req_valid/req_ready : per-requester handshake, req_ready one-hot or zero
//   req_a/req_b         : packed operands, requester k at bits [32k+31:32k]
//   mul_a/mul_b/mul_p   : operands to and product from the shared multiplier
//   rsp_*               : valid/ready response carrying owner ID and product
//   busy                : arbiter is not idle
interface mult_share_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic [63:0]     mul_p;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [63:0]     rsp_prod;
  logic            busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one combinational 32x32 unsigned multiplier among
// N requesters. The winner's operands are latched and held on mul_a/mul_b for a
// MUL_LAT-cycle settle window, after which the 64-bit product is captured and
// returned with the requester ID on a valid/ready response channel.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mult_share_arbiter_if.slave (requests, multiplier, response, busy)
module mult_share_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mult_share_arbiter_if.slave   bus
);
  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [CW-1:0]  cnt_reg;
  logic [31:0]    op_a_reg;
  logic [31:0]    op_b_reg;
  logic           rsp_valid_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [63:0]    rsp_prod_reg;

  logic           grant_any;
  logic [IDW-1:0] winner;

  // Scan requesters starting at ptr and wrapping; first valid one wins.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    winner    = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= N) idx = idx - N;
      if (!grant_any && bus.req_valid[IDW'(idx)]) begin
        grant_any = 1'b1;
        winner    = IDW'(idx);
      end
    end
  end

  // Grant only in IDLE; gated by rst so nothing is offered while held in reset.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && state_reg == IDLE && grant_any)
      bus.req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_prod_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            op_a_reg   <= bus.req_a[{winner, 5'd0} +: 32];
            op_b_reg   <= bus.req_b[{winner, 5'd0} +: 32];
            rsp_id_reg <= winner;
            cnt_reg    <= CW'(MUL_LAT);
            state_reg  <= CALC;
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg - CW'(1);
          // Last settle cycle: the multiplier output is stable, capture it.
          if (cnt_reg == CW'(1)) begin
            rsp_prod_reg  <= bus.mul_p;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            // Next search starts just past the requester we served.
            ptr_reg   <= (rsp_id_reg == IDW'(N - 1)) ? '0 : rsp_id_reg + IDW'(1);
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.mul_a     = op_a_reg;
  assign bus.mul_b     = op_b_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_prod  = rsp_prod_reg;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: reset, single request, round-robin
// rotation, response backpressure, reset mid-operation and edge operands.
// Expected responses are queued when a grant is driven and popped by a monitor
// when the response handshake occurs.
module tb_mult_share_arbiter;
  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_share_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  // Behavioural stand-in for the shared Wallace-tree multiplier.
  assign bus.mul_p = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};

  mult_share_arbiter #(.N(N), .IDW(IDW), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    prod;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        check("rsp_prod", bus.rsp_prod, e.prod);
        $display("[TB] rsp id=%0d prod=%h", bus.rsp_id, bus.rsp_prod);
      end
    end
  end

  task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[k*32 +: 32] = a;
    bus.req_b[k*32 +: 32] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) tick();
    check("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && bus.req_ready == '0; i++) tick();
    check("rdy_timeout", 64'(|bus.req_ready), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One isolated operation from requester k with rsp_ready held high.
  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_prod);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[k] = 1'b1;
    set_ops(k, a, b);
    bus.req_valid = onehot;
    #1;
    check("op_req_ready", 64'(bus.req_ready), 64'(onehot));
    sb.push_back('{id: IDW'(k), prod: exp_prod});
    tick();
    bus.req_valid = '0;
    check("op_busy", 64'(bus.busy), 64'd1);
    check("op_mul_a", 64'(bus.mul_a), 64'(a));
    check("op_mul_b", 64'(bus.mul_b), 64'(b));
    for (int i = 0; i < MUL_LAT; i++) begin
      check("op_rsp_early", 64'(bus.rsp_valid), 64'd0);
      tick();
    end
    check("op_rsp_rise", 64'(bus.rsp_valid), 64'd1);
    tick();
    check("op_rsp_drop", 64'(bus.rsp_valid), 64'd0);
    check("op_idle", 64'(bus.busy), 64'd0);
    $display("[TB] op k=%0d a=%h b=%h done", k, a, b);
  endtask

  initial begin
    logic [N-1:0] onehot;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset / idle
    tick();
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick();
    tick();
    check("idle_req_ready", 64'(bus.req_ready), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("idle_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("idle_rsp_prod", bus.rsp_prod, 64'd0);
    check("idle_mul_a", 64'(bus.mul_a), 64'd0);
    check("idle_mul_b", 64'(bus.mul_b), 64'd0);
    $display("[TB] reset/idle done");

    // Single request, full-scale operands
    do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    // Round-robin rotation from reset
    do_reset();
    for (int k = 0; k < N; k++) set_ops(k, 32'(k + 1), 32'd10);
    bus.req_valid = '1;
    #1;
    for (int op = 0; op < 5; op++) begin
      wait_ready();
      onehot = '0;
      onehot[op % N] = 1'b1;
      check("rr_grant", 64'(bus.req_ready), 64'(onehot));
      sb.push_back('{id: IDW'(op % N), prod: 64'((op % N + 1) * 10)});
      $display("[TB] rr op=%0d grant=%b", op, bus.req_ready);
      tick();
      wait_rsp();
      tick();
    end
    bus.req_valid = '0;
    tick();
    check("rr_sb_drained", 64'(sb.size()), 64'd0);

    // Backpressure with requester 2 held valid throughout
    bus.rsp_ready = 1'b0;
    set_ops(2, 32'd7, 32'd9);
    bus.req_valid = 4'b0100;
    #1;
    check("bp_grant", 64'(bus.req_ready), 64'h4);
    sb.push_back('{id: IDW'(2), prod: 64'd63});
    tick();
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_rsp_id", 64'(bus.rsp_id), 64'd2);
      check("bp_rsp_prod", bus.rsp_prod, 64'd63);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
      check("bp_mul_a", 64'(bus.mul_a), 64'd7);
      check("bp_mul_b", 64'(bus.mul_b), 64'd9);
      $display("[TB] bp stall cycle %0d", i);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_hs_cycle_ready", 64'(bus.req_ready), 64'd0);
    tick();
    check("bp_after_valid", 64'(bus.rsp_valid), 64'd0);
    check("bp_after_ready", 64'(bus.req_ready), 64'h4);
    check("bp_retain_prod", bus.rsp_prod, 64'd63);
    check("bp_retain_id", 64'(bus.rsp_id), 64'd2);
    bus.req_valid = '0;
    tick();
    check("bp_idle", 64'(bus.busy), 64'd0);

    // Reset during CALC for requester 3
    set_ops(3, 32'd5, 32'd6);
    bus.req_valid = 4'b1000;
    #1;
    check("mr_grant", 64'(bus.req_ready), 64'h8);
    tick();
    check("mr_busy", 64'(bus.busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_busy_rst", 64'(bus.busy), 64'd0);
    check("mr_req_ready_rst", 64'(bus.req_ready), 64'd0);
    check("mr_rsp_valid_rst", 64'(bus.rsp_valid), 64'd0);
    check("mr_rsp_id_rst", 64'(bus.rsp_id), 64'd0);
    check("mr_rsp_prod_rst", bus.rsp_prod, 64'd0);
    check("mr_mul_a_rst", 64'(bus.mul_a), 64'd0);
    check("mr_mul_b_rst", 64'(bus.mul_b), 64'd0);
    tick();
    rst = 1'b0;
    set_ops(0, 32'd0, 32'h1234_5678);
    bus.req_valid = '1;
    #1;
    check("mr_next_grant", 64'(bus.req_ready), 64'h1);
    sb.push_back('{id: IDW'(0), prod: 64'd0});
    tick();
    bus.req_valid = '0;
    wait_rsp();
    tick();
    check("mr_idle", 64'(bus.busy), 64'd0);

    // Edge operand
    do_op(1, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
